mag_window_stats: RTL and testbench
===================================

# mag_window_stats

Downstream statistics stage for the magnitude datapath. It consumes the 8-bit magnitude results (sqrt of x²+y²) produced by the magnitude engine, one per valid strobe. It accumulates them over a fixed power-of-two window and publishes the window average and peak. It also drives a hysteresis alarm from the average against two programmable thresholds.

## Interface

Parameters:
- WIN_LOG2, default 3: log2 of window length N (N = 8 by default); legal range 1..4.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; low freezes all state
- mag_in  input  8  magnitude sample from upstream sqrt stage
- mag_valid  input  1  mag_in accepted on a rising edge when high and ena=1
- clr  input  1  synchronous window restart
- thr_hi  input  8  alarm set threshold
- thr_lo  input  8  alarm clear threshold
- avg_out  output  8  last completed window average, registered
- peak_out  output  8  last completed window maximum, registered
- stats_valid  output  1  one-cycle pulse: avg_out/peak_out just updated
- alarm  output  1  hysteresis alarm, registered
- win_cnt  output  WIN_LOG2  samples accepted in current window

## Operation

- Internal state: sum (8+WIN_LOG2 bits), peak (8 bits), cnt (WIN_LOG2 bits, also drives win_cnt).
- Reset: avg_out=0, peak_out=0, stats_valid=0, alarm=0, win_cnt=0, sum=0, peak=0.
- ena=0: nothing accepted; all registers hold; stats_valid forced 0.
- Accept (ena & mag_valid & !clr):
  - cnt < N-1: sum += mag_in; peak = max(peak, mag_in); cnt += 1.
  - cnt == N-1 (window close):
    - avg_out = (sum + mag_in) >> WIN_LOG2 (truncating).
    - peak_out = max(peak, mag_in).
    - stats_valid = 1 next cycle.
    - sum, peak, cnt = 0.
- Alarm is evaluated only at window close, using the new average:
  - new avg ≥ thr_hi: alarm = 1.
  - else new avg < thr_lo: alarm = 0.
  - else alarm holds.
  - thr_hi rule has priority, which also covers thr_lo > thr_hi.
- clr (with ena=1): sum, peak, cnt = 0; any sample in the same cycle is dropped. avg_out, peak_out and alarm hold. stats_valid = 0.
- Arithmetic: sum width never overflows (N·255 fits in 8+WIN_LOG2 bits); peak compare is unsigned.

## Timing

- Registered outputs change on the rising edge that accepts the N-th sample.
- stats_valid is high for exactly the cycle after that edge, then low, unless the next window also closes.
- A window of N samples can close as early as N consecutive accepting cycles. Back-to-back windows give one stats_valid pulse every N cycles.
- No backpressure: upstream may present mag_valid every cycle, and every qualified sample is consumed.
- Gaps in mag_valid stretch the window; no timeout.
- Async reset mid-window discards partial sum and peak immediately, with no clock needed. The first window after reset release starts at cnt=0.
- Threshold inputs are sampled only on the window-close edge. Changes at other times have no effect until the next close.

## Test plan

- Reset/idle:
  - Stimulus: assert rst_n=0 mid-window (cnt=5), then release.
  - Required: all outputs 0 immediately; the next 8 samples of 10 give avg_out=10, peak_out=10, and one stats_valid pulse.
- Average/peak:
  - Stimulus: samples 1,2,3,4,5,6,7,100 back-to-back.
  - Required: avg_out=16 (128>>3), peak_out=100, stats_valid high exactly one cycle after the 8th edge.
- Full-scale:
  - Stimulus: eight samples of 255.
  - Required: avg_out=255, peak_out=255, no overflow.
- Hysteresis (thr_hi=50, thr_lo=30):
  - Stimulus: window averages 40, 60, 40, 29, 45.
  - Required: alarm 0, 1, 1, 0, 0.
  - Also: with thr_lo=70, thr_hi=50 and avg 60, alarm=1.
- clr/ena interaction:
  - Stimulus: 5 samples, then clr coincident with a valid sample.
  - Required: win_cnt=0 and the sample dropped; 8 more samples are needed before stats_valid.
  - Stimulus: toggle ena=0 with mag_valid=1 for 3 cycles.
  - Required: win_cnt unchanged, stats_valid=0.
- Gapped input:
  - Stimulus: 8 samples of value 20 with random 0–3 idle cycles between them.
  - Required: single stats_valid pulse after the 8th accept, avg_out=20.

Source files
------------

// File: rtl/mag_window_stats.sv
// -----------------------------------------------------------------------------
// mag_window_stats
//
// Statistics stage behind the magnitude engine. It accumulates accepted 8-bit
// magnitude samples over a window of N = 2**WIN_LOG2 samples. When a window
// closes it publishes the truncated average and the maximum of that window.
// It also updates a hysteresis alarm from the new average.
//
// Ports:
//   clk         in   system clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   ena         in   global enable; low freezes all state
//   mag_in      in   [7:0] magnitude sample
//   mag_valid   in   mag_in qualifier (accepted when ena=1 and clr=0)
//   clr         in   synchronous window restart (drops same-cycle sample)
//   thr_hi      in   [7:0] alarm set threshold (sampled at window close)
//   thr_lo      in   [7:0] alarm clear threshold (sampled at window close)
//   avg_out     out  [7:0] average of last completed window
//   peak_out    out  [7:0] maximum of last completed window
//   stats_valid out  one-cycle pulse after avg_out/peak_out update
//   alarm       out  hysteresis alarm
//   win_cnt     out  [WIN_LOG2-1:0] samples accepted in current window
// -----------------------------------------------------------------------------
module mag_window_stats #(
    parameter int WIN_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [7:0]          mag_in,
    input  logic                mag_valid,
    input  logic                clr,
    input  logic [7:0]          thr_hi,
    input  logic [7:0]          thr_lo,
    output logic [7:0]          avg_out,
    output logic [7:0]          peak_out,
    output logic                stats_valid,
    output logic                alarm,
    output logic [WIN_LOG2-1:0] win_cnt
);

    localparam int SUM_W = 8 + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = {WIN_LOG2{1'b1}};

    logic [SUM_W-1:0]    sum_reg;
    logic [7:0]          peak_reg;
    logic [WIN_LOG2-1:0] cnt_reg;
    logic [7:0]          avg_reg;
    logic [7:0]          peak_out_reg;
    logic                stats_valid_reg;
    logic                alarm_reg;

    logic                accept;
    logic                close;
    logic [SUM_W-1:0]    sum_next;
    logic [7:0]          peak_next;
    logic [7:0]          avg_next;

    // clr wins over a coincident sample, so it is folded into the qualifier.
    assign accept    = ena & mag_valid & ~clr;
    assign close     = accept & (cnt_reg == CNT_LAST);

    // Running totals including the sample currently on the input.
    assign sum_next  = sum_reg + {{WIN_LOG2{1'b0}}, mag_in};
    assign peak_next = (mag_in > peak_reg) ? mag_in : peak_reg;

    // N*255 fits in SUM_W bits, so the top 8 bits are exactly sum/N.
    assign avg_next  = sum_next[SUM_W-1:WIN_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg         <= '0;
            peak_reg        <= '0;
            cnt_reg         <= '0;
            avg_reg         <= '0;
            peak_out_reg    <= '0;
            stats_valid_reg <= 1'b0;
            alarm_reg       <= 1'b0;
        end else begin
            // close already carries ena, so a frozen stage never pulses.
            stats_valid_reg <= close;
            if (ena) begin
                if (clr) begin
                    sum_reg  <= '0;
                    peak_reg <= '0;
                    cnt_reg  <= '0;
                end else if (close) begin
                    sum_reg      <= '0;
                    peak_reg     <= '0;
                    cnt_reg      <= '0;
                    avg_reg      <= avg_next;
                    peak_out_reg <= peak_next;
                    // Set threshold is checked first so an inverted
                    // threshold pair still raises the alarm.
                    if (avg_next >= thr_hi) begin
                        alarm_reg <= 1'b1;
                    end else if (avg_next < thr_lo) begin
                        alarm_reg <= 1'b0;
                    end
                end else if (accept) begin
                    sum_reg  <= sum_next;
                    peak_reg <= peak_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign avg_out     = avg_reg;
    assign peak_out    = peak_out_reg;
    assign stats_valid = stats_valid_reg;
    assign alarm       = alarm_reg;
    assign win_cnt     = cnt_reg;

endmodule

// File: tb/tb_mag_window_stats.sv
// -----------------------------------------------------------------------------
// tb_mag_window_stats
//
// Directed bench for mag_window_stats (WIN_LOG2=3, N=8). A table of vectors
// covers average/peak, hysteresis and full-scale windows. Hand-written
// sequences then cover async reset mid-window, clr, ena freeze and gapped
// input.
// -----------------------------------------------------------------------------
module tb_mag_window_stats;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] mag_in;
    logic       mag_valid;
    logic       clr;
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic [7:0] avg_out;
    logic [7:0] peak_out;
    logic       stats_valid;
    logic       alarm;
    logic [2:0] win_cnt;

    mag_window_stats #(.WIN_LOG2(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .mag_in     (mag_in),
        .mag_valid  (mag_valid),
        .clr        (clr),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .avg_out    (avg_out),
        .peak_out   (peak_out),
        .stats_valid(stats_valid),
        .alarm      (alarm),
        .win_cnt    (win_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic       v;
        logic       c;
        logic [7:0] mag;
        logic [7:0] thi;
        logic [7:0] tlo;
        logic [7:0] avg;
        logic [7:0] peak;
        logic       sv;
        logic       al;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[128];
    int   nvec;
    int   n_cmp;
    int   n_bad;

    // Model of the published state while the table is being built.
    logic [7:0] m_avg;
    logic [7:0] m_peak;
    logic       m_alarm;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic e, input logic v, input logic c,
                        input logic [7:0] mag, input logic [7:0] thi,
                        input logic [7:0] tlo, input logic [7:0] avg,
                        input logic [7:0] peak, input logic sv,
                        input logic al, input logic [2:0] cnt);
        vecs[nvec] = '{e, v, c, mag, thi, tlo, avg, peak, sv, al, cnt};
        nvec++;
    endtask

    // Eight samples of v. thi_mid is on thr_hi before the close, thi at the
    // close, which checks that thresholds are only sampled then.
    task automatic push_window(input logic [7:0] v, input logic [7:0] thi_mid,
                               input logic [7:0] thi, input logic [7:0] tlo,
                               input logic exp_alarm);
        for (int i = 0; i < 7; i++)
            push(1, 1, 0, v, thi_mid, tlo, m_avg, m_peak, 0, m_alarm, 3'(i + 1));
        push(1, 1, 0, v, thi, tlo, v, v, 1, exp_alarm, 0);
        m_avg   = v;
        m_peak  = v;
        m_alarm = exp_alarm;
        push(1, 0, 0, 0, thi, tlo, m_avg, m_peak, 0, m_alarm, 0);
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic drive(input logic e, input logic v, input logic [7:0] mag,
                         input logic c);
        ena       = e;
        mag_valid = v;
        mag_in    = mag;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nvec  = 0;
        m_avg = 0;
        m_peak = 0;
        m_alarm = 0;

        // ---------------- table construction ----------------
        // Average/peak: 1..7,100 -> sum 128, avg 16, peak 100.
        for (int i = 1; i <= 7; i++)
            push(1, 1, 0, 8'(i), 50, 30, 0, 0, 0, 0, 3'(i));
        push(1, 1, 0, 100, 50, 30, 16, 100, 1, 0, 0);
        m_avg = 16; m_peak = 100; m_alarm = 0;
        push(1, 0, 0, 0, 50, 30, 16, 100, 0, 0, 0);
        // Hysteresis with thr_hi=50, thr_lo=30.
        push_window(40, 50, 50, 30, 0);
        push_window(60, 50, 50, 30, 1);
        push_window(40, 50, 50, 30, 1);
        push_window(29, 50, 50, 30, 0);
        push_window(45, 50, 50, 30, 0);
        push_window(50, 50, 50, 30, 1);   // equal to thr_hi sets
        push_window(30, 50, 50, 30, 1);   // equal to thr_lo holds
        push_window(10, 50, 50, 30, 0);
        // Inverted thresholds; thr_hi is 255 until the closing sample.
        push_window(60, 255, 50, 70, 1);
        // Full scale.
        push_window(255, 50, 50, 30, 1);

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        ena       = 1'b0;
        mag_valid = 1'b0;
        mag_in    = 0;
        clr       = 1'b0;
        thr_hi    = 50;
        thr_lo    = 30;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_avg",   avg_out, 0);
        chk("reset_peak",  peak_out, 0);
        chk("reset_sv",    stats_valid, 0);
        chk("reset_alarm", alarm, 0);
        chk("reset_cnt",   win_cnt, 0);

        // ---------------- table ----------------
        for (int i = 0; i < nvec; i++) begin
            thr_hi = vecs[i].thi;
            thr_lo = vecs[i].tlo;
            drive(vecs[i].e, vecs[i].v, vecs[i].mag, vecs[i].c);
            $display("vec %0d: mag=%0d v=%0d -> avg=%0d peak=%0d sv=%0d al=%0d cnt=%0d",
                     i, vecs[i].mag, vecs[i].v, avg_out, peak_out, stats_valid,
                     alarm, win_cnt);
            chk($sformatf("vec%0d_avg", i),   avg_out,     vecs[i].avg);
            chk($sformatf("vec%0d_peak", i),  peak_out,    vecs[i].peak);
            chk($sformatf("vec%0d_sv", i),    stats_valid, vecs[i].sv);
            chk($sformatf("vec%0d_alarm", i), alarm,       vecs[i].al);
            chk($sformatf("vec%0d_cnt", i),   win_cnt,     vecs[i].cnt);
        end
        thr_hi = 50;
        thr_lo = 30;

        // ---------------- async reset mid-window ----------------
        for (int i = 0; i < 5; i++) drive(1, 1, 200, 0);
        chk("midrst_cnt_before", win_cnt, 5);
        mag_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("midrst_avg",   avg_out, 0);
        chk("midrst_peak",  peak_out, 0);
        chk("midrst_alarm", alarm, 0);
        chk("midrst_cnt",   win_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 10, 0);
            pulses += int'(stats_valid);
        end
        $display("after reset window: avg=%0d peak=%0d sv=%0d", avg_out, peak_out, stats_valid);
        chk("rstwin_sv",   stats_valid, 1);
        chk("rstwin_avg",  avg_out, 10);
        chk("rstwin_peak", peak_out, 10);
        drive(1, 0, 0, 0);
        pulses += int'(stats_valid);
        chk("rstwin_pulses", pulses, 1);

        // ---------------- clr with coincident sample ----------------
        for (int i = 0; i < 5; i++) drive(1, 1, 10, 0);
        drive(1, 1, 250, 1);
        $display("clr: cnt=%0d sv=%0d avg=%0d", win_cnt, stats_valid, avg_out);
        chk("clr_cnt", win_cnt, 0);
        chk("clr_sv",  stats_valid, 0);
        chk("clr_avg_hold", avg_out, 10);
        for (int i = 0; i < 7; i++) drive(1, 1, 40, 0);
        chk("clr_cnt7", win_cnt, 7);
        chk("clr_sv7",  stats_valid, 0);
        drive(1, 1, 40, 0);
        chk("clr_sv8",   stats_valid, 1);
        chk("clr_avg",   avg_out, 40);
        chk("clr_peak",  peak_out, 40);
        chk("clr_alarm", alarm, 0);

        // ---------------- ena freeze ----------------
        for (int i = 0; i < 3; i++) drive(1, 1, 60, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 250, 0);
            $display("ena low %0d: cnt=%0d sv=%0d", i, win_cnt, stats_valid);
            chk($sformatf("ena_cnt%0d", i), win_cnt, 3);
            chk($sformatf("ena_sv%0d", i),  stats_valid, 0);
        end
        for (int i = 0; i < 4; i++) drive(1, 1, 60, 0);
        chk("ena_sv_pre", stats_valid, 0);
        drive(1, 1, 60, 0);
        chk("ena_sv",    stats_valid, 1);
        chk("ena_avg",   avg_out, 60);
        chk("ena_peak",  peak_out, 60);
        chk("ena_alarm", alarm, 1);

        // ---------------- gapped input ----------------
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, 20, 0);
            pulses += int'(stats_valid);
            if (k == 7) begin
                $display("gapped close: avg=%0d sv=%0d alarm=%0d", avg_out, stats_valid, alarm);
                chk("gap_sv",    stats_valid, 1);
                chk("gap_avg",   avg_out, 20);
                chk("gap_peak",  peak_out, 20);
                chk("gap_alarm", alarm, 0);
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                drive(1, 0, 99, 0);
                pulses += int'(stats_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0);
            pulses += int'(stats_valid);
        end
        chk("gap_pulses", pulses, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
